// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the N-to-1 RAM arbiter.
// The arbiter has two states: no owner, or one port owns the RAM.
package ram_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    function automatic int be_width(input int data_bits);
        return data_bits / 8;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of all requester-side and RAM-side signals of the arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the RAM around it.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
);
    localparam int BE_W = be_width(DATA_BITS);

    logic [NUM_PORTS-1:0][ADDR_BITS-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_BITS-1:0] req_wdata;
    logic [NUM_PORTS-1:0][BE_W-1:0]      req_byte_en;
    logic [NUM_PORTS-1:0]                req_ren;
    logic [NUM_PORTS-1:0]                req_wen;
    logic [NUM_PORTS-1:0][DATA_BITS-1:0] req_rdata;
    logic [NUM_PORTS-1:0]                req_busy;

    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [BE_W-1:0]      mem_byte_en;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 mem_busy;

    modport slave (
        input  req_addr, req_wdata, req_byte_en, req_ren, req_wen,
        output req_rdata, req_busy,
        output mem_addr, mem_wdata, mem_byte_en, mem_ren, mem_wen,
        input  mem_rdata, mem_busy
    );

    modport master (
        output req_addr, req_wdata, req_byte_en, req_ren, req_wen,
        input  req_rdata, req_busy,
        input  mem_addr, mem_wdata, mem_byte_en, mem_ren, mem_wen,
        output mem_rdata, mem_busy
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request bit at or after ptr_i, wrapping.
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 vld_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the closest requester overwrites last.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_PORTS);
            if (req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// N-to-1 round-robin arbiter on the busy/ren/wen RAM handshake.
// A granted port owns the RAM until it completes (mem_busy low) or withdraws its request.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    ram_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0] req_any;
    logic                 owner_req;
    logic [IDX_W-1:0]     owner_nxt;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;

    assign req_any   = bus.req_ren | bus.req_wen;
    assign owner_req = req_any[owner_q];
    assign owner_nxt = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + IDX_W'(1);

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i (req_any),
        .ptr_i (rr_ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_byte_en = '0;
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.req_busy    = '1;
        bus.req_rdata   = '0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    state_d = OWNED;
                end
            end

            OWNED: begin
                bus.mem_addr    = bus.req_addr[owner_q];
                bus.mem_wdata   = bus.req_wdata[owner_q];
                bus.mem_byte_en = bus.req_byte_en[owner_q];
                if (!owner_req) begin
                    // Withdrawal: release the RAM without signalling completion.
                    state_d  = IDLE;
                    rr_ptr_d = owner_nxt;
                end else begin
                    bus.mem_wen = bus.req_wen[owner_q];
                    bus.mem_ren = bus.req_ren[owner_q] & ~bus.req_wen[owner_q];
                    if (!bus.mem_busy) begin
                        bus.req_busy[owner_q]  = 1'b0;
                        bus.req_rdata[owner_q] = bus.mem_rdata;
                        state_d  = IDLE;
                        rr_ptr_d = owner_nxt;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
